// File: rtl/kernel_d_vout_obuf_if.sv
// Output-buffer bundle between the vout stage, the buffer and its consumer.
//   in_data/in_valid : result words from upstream (driven by master)
//   stall            : back-pressure to upstream (driven by slave)
//   out_data/out_valid/out_ready : FWFT head word handshake to the consumer
//   count/overflow   : occupancy and sticky drop flag (driven by slave)
// slave = the buffer itself, master = the environment around it.
interface kernel_d_vout_obuf_if #(
  parameter int unsigned DATAW = 32,
  parameter int unsigned DEPTH = 8
);
  logic [DATAW-1:0]         in_data;
  logic                     in_valid;
  logic                     stall;
  logic [DATAW-1:0]         out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [$clog2(DEPTH):0]   count;
  logic                     overflow;

  modport slave (
    input  in_data, in_valid, out_ready,
    output stall, out_data, out_valid, count, overflow
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  stall, out_data, out_valid, count, overflow
  );
endinterface

// File: rtl/kernel_d_vout_obuf.sv
// Output FIFO behind the vout stage: circular buffer of DEPTH words with
// first-word-fall-through read, registered stall with SKID slots of headroom
// for words already in flight, and a sticky overflow flag for dropped words.
// Ports:
//   clk  : single clock, rising edge
//   rst  : asynchronous active-low reset, release synchronised by two flops
//   bus  : kernel_d_vout_obuf_if.slave (in_*, stall, out_*, count, overflow)
module kernel_d_vout_obuf #(
  parameter int unsigned DATAW = 32,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned SKID  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  kernel_d_vout_obuf_if.slave   bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_AT  = CW'(DEPTH);
  localparam logic [CW-1:0] STALL_AT = CW'(DEPTH - SKID);

  logic [1:0]       r_sync;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_stall;
  logic             r_overflow;
  logic [DATAW-1:0] r_mem [DEPTH];

  logic w_run;
  logic w_pop;
  logic w_push;
  logic w_drop;

  // Async assert; release only after two clean edges, and no push before that.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_sync <= '0;
    else      r_sync <= {r_sync[0], 1'b1};
  end

  assign w_run  = r_sync[1];
  assign w_pop  = bus.out_valid & bus.out_ready;
  assign w_push = w_run & bus.in_valid & ((r_count < FULL_AT) | w_pop);
  assign w_drop = w_run & bus.in_valid & ~w_push;

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.in_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_stall    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      // Registered from current occupancy: lags the count change by a cycle.
      r_stall <= (r_count >= STALL_AT);
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  assign bus.out_valid = (r_count != '0);
  assign bus.out_data  = r_mem[r_rd_ptr];
  assign bus.count     = r_count;
  assign bus.stall     = r_stall;
  assign bus.overflow  = r_overflow;
endmodule

// File: tb/tb_kernel_d_vout_obuf.sv
// Scoreboard bench for kernel_d_vout_obuf (DATAW=32, DEPTH=8, SKID=2).
module tb_kernel_d_vout_obuf;
  localparam int unsigned DATAW = 32;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned SKID  = 2;

  logic clk;
  logic rst;

  kernel_d_vout_obuf_if #(.DATAW(DATAW), .DEPTH(DEPTH)) bus ();

  kernel_d_vout_obuf #(.DATAW(DATAW), .DEPTH(DEPTH), .SKID(SKID)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [DATAW-1:0] q[$];
  int   m_cnt   = 0;
  logic m_stall = 1'b0;
  logic m_ovf   = 1'b0;
  int   m_sync  = 0;
  logic dead_seen = 1'b0;
  logic [DATAW-1:0] d_next = 32'd1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Called at the falling edge: check outputs against the model, then
  // advance the model by what the next rising edge will do.
  task automatic model_eval();
    logic run, pop, push;
    logic [DATAW-1:0] exp_d;
    run = (m_sync >= 2);
    chk("count",    64'(bus.count),     64'(m_cnt));
    chk("out_valid",64'(bus.out_valid), 64'(m_cnt != 0));
    chk("stall",    64'(bus.stall),     64'(m_stall));
    chk("overflow", 64'(bus.overflow),  64'(m_ovf));
    if (bus.out_valid && bus.out_data == 32'hDEAD) dead_seen = 1'b1;
    pop = (m_cnt != 0) && bus.out_ready;
    if (pop) begin
      exp_d = q.pop_front();
      chk("out_data", 64'(bus.out_data), 64'(exp_d));
    end
    push = run && bus.in_valid && ((m_cnt < int'(DEPTH)) || pop);
    if (run && bus.in_valid && !push) m_ovf = 1'b1;
    m_stall = (m_cnt >= int'(DEPTH - SKID));
    if (push) q.push_back(bus.in_data);
    m_cnt = m_cnt + int'(push) - int'(pop);
  endtask

  task automatic tick();
    @(negedge clk);
    model_eval();
    @(posedge clk);
    if (rst && m_sync < 3) m_sync++;
    #1;
  endtask

  // Entered just after a rising edge; holds reset low for one cycle.
  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_count",     64'(bus.count),     64'd0);
    chk("rst_stall",     64'(bus.stall),     64'd0);
    chk("rst_overflow",  64'(bus.overflow),  64'd0);
    q.delete();
    m_cnt = 0; m_stall = 1'b0; m_ovf = 1'b0; m_sync = 0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic push_word();
    bus.in_valid = 1'b1;
    bus.in_data  = d_next;
    d_next       = d_next + 32'd1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Words offered during the two-flop release must be ignored.
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h77;
    tick();
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk("release_ignored", 64'(bus.count), 64'd0);

    // Three words in, then drained in order.
    for (int i = 0; i < 3; i++) push_word();
    tick();
    chk("cnt3",   64'(bus.count),     64'd3);
    chk("valid3", 64'(bus.out_valid), 64'd1);
    chk("head1",  64'(bus.out_data),  64'd1);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    bus.out_ready = 1'b0;
    tick();
    chk("drained_cnt",   64'(bus.count),     64'd0);
    chk("drained_valid", 64'(bus.out_valid), 64'd0);

    // Stall threshold and fill to full.
    for (int i = 0; i < 6; i++) push_word();
    chk("stall_lag", 64'(bus.stall), 64'd0);
    tick();
    chk("stall_up", 64'(bus.stall), 64'd1);
    for (int i = 0; i < 2; i++) push_word();
    tick();
    chk("full_cnt", 64'(bus.count),    64'd8);
    chk("full_ovf", 64'(bus.overflow), 64'd0);

    // Full with simultaneous push and pop.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = d_next;
      d_next       = d_next + 32'd1;
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    chk("thru_cnt", 64'(bus.count),    64'd8);
    chk("thru_ovf", 64'(bus.overflow), 64'd0);

    // Overflow: the word is dropped and must never surface.
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hDEAD;
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk("ovf_set", 64'(bus.overflow), 64'd1);
    chk("ovf_cnt", 64'(bus.count),    64'd8);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    bus.out_ready = 1'b0;
    tick();
    chk("ovf_drained", 64'(bus.count), 64'd0);
    chk("dead_absent", 64'(dead_seen), 64'd0);
    chk("ovf_sticky",  64'(bus.overflow), 64'd1);

    // Mid-stream reset with five buffered words.
    for (int i = 0; i < 5; i++) push_word();
    tick();
    chk("pre_rst_cnt", 64'(bus.count), 64'd5);
    do_reset();
    tick();
    tick();
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hA5;
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk("post_rst_valid", 64'(bus.out_valid), 64'd1);
    chk("post_rst_head",  64'(bus.out_data),  64'hA5);
    chk("post_rst_cnt",   64'(bus.count),     64'd1);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;

    // Random traffic; upstream honours stall.
    for (int i = 0; i < 10000; i++) begin
      bus.in_valid  = ($urandom_range(0, 1) == 1) && !bus.stall;
      bus.in_data   = $urandom;
      bus.out_ready = ($urandom_range(0, 1) == 1);
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20 && m_cnt != 0; i++) tick();
    tick();
    chk("final_cnt",   64'(bus.count),    64'd0);
    chk("final_queue", 64'(q.size()),     64'd0);
    chk("final_ovf",   64'(bus.overflow), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/kernel_d_vout_obuf.md
KERNEL_D_VOUT_OBUF -- requirements
Module: kernel_D_vout_obuf

Interface
REQ-001 Parameter DATAW, default 32, data word width; matches the upstream vout stage.
REQ-002 Parameter DEPTH, default 8, FIFO entries; power of two, >= 4.
REQ-003 Parameter SKID, default 2, free entries reserved for words already in flight when stall rises.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low (asserted at 0).
REQ-006 in_data  input  DATAW  registered result word from the upstream vout stage.
REQ-007 in_valid  input  1  in_data carries a new word this cycle.
REQ-008 stall  output  1  back-pressure to the upstream pipeline; drives its stall input.
REQ-009 out_data  output  DATAW  head-of-FIFO word, first-word-fall-through.
REQ-010 out_valid  output  1  out_data holds a valid word.
REQ-011 out_ready  input  1  downstream consumer accepts out_data this cycle.
REQ-012 count  output  log2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-013 overflow  output  1  sticky flag: a word was dropped.

Function
REQ-014 Storage: circular buffer of DEPTH words; write pointer and read pointer, each log2(DEPTH) bits, wrap from DEPTH-1 to 0.
REQ-015 push = in_valid and (count < DEPTH or pop); pop = out_valid and out_ready.
REQ-016 On push, in_data is written at the write pointer and the write pointer increments.
REQ-017 On pop, the read pointer increments.
REQ-018 count update: +1 on push only, -1 on pop only, unchanged on push and pop together or on neither.
REQ-019 Full with simultaneous push and pop: both take effect; count stays DEPTH; no data loss.
REQ-020 Empty with in_valid: the word is written, and out_valid rises the next cycle; no same-cycle bypass.
REQ-021 out_valid = (count != 0); out_data = buffer[read pointer], combinational from storage; out_data is undefined-but-stable when out_valid is 0.
REQ-022 out_ready while empty has no effect; count never underflows.
REQ-023 stall = (count >= DEPTH-SKID), registered; updates one cycle after the count change.
REQ-024 in_valid when count == DEPTH and no pop: the word is discarded, pointers and count are unchanged, and overflow is set to 1.
REQ-025 overflow stays 1 until reset.
REQ-026 Words leave in exact arrival order with no duplication; latency from accepted push to out_valid is 1 cycle when the FIFO was empty.

Reset
REQ-027 rst low asynchronously clears the pointers, count, stall, and overflow to 0; out_valid = 0 immediately.
REQ-028 Storage contents are not reset.
REQ-029 rst deassertion is synchronised internally (two-flop release); the first push is accepted no earlier than the second rising edge after rst goes high.
REQ-030 rst asserted mid-stream discards all buffered words; no partial word is presented after release.

Verification
REQ-031 Bench: after reset, push 1,2,3 on consecutive cycles with out_ready=0 -> count=3, out_valid=1, out_data=1; then out_ready=1 for 3 cycles -> out_data sequence 1,2,3, then count=0, out_valid=0.
REQ-032 Bench (DEPTH=8, SKID=2): push 6 words with out_ready=0 -> stall=1 on the cycle after count reaches 6; push 2 more -> count=8, overflow=0.
REQ-033 Bench: full FIFO, in_valid=1 and out_ready=1 for 10 cycles with incrementing data -> count stays 8, output order is unbroken, overflow=0.
REQ-034 Bench: full FIFO, in_valid=1 with data 0xDEAD and out_ready=0 -> overflow=1, count=8, and 0xDEAD never appears at out_data.
REQ-035 Bench: reset pulsed low for 1 cycle while count=5 -> out_valid=0, count=0, stall=0, overflow=0 immediately; new data 0xA5 after release is the first word out.
REQ-036 Bench: random in_valid/out_ready at 50% for 10k cycles, with a scoreboard -> in-order, lossless output whenever the stall contract holds (upstream stops within SKID cycles).
